// File: rtl/spif_common_pkg.sv
// Shared event-path definitions for the sensor-interface blocks: event type,
// grant record and the round-robin search used by the event arbiters.
package spif_common_pkg;

    localparam int EVT_BITS   = 32;
    localparam int MAX_INPUTS = 8;

    typedef logic [EVT_BITS-1:0] evt_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } grant_t;

    // First requester at or after ptr, wrapping modulo n (n <= MAX_INPUTS).
    function automatic grant_t rr_next_grant(input logic [MAX_INPUTS-1:0] vld,
                                             input logic [2:0]            ptr,
                                             input int                    n);
        grant_t g;
        int     idx;
        g = '0;
        for (int k = 0; k < MAX_INPUTS; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !g.found && vld[3'(idx)]) begin
                g.found = 1'b1;
                g.idx   = 3'(idx);
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/evt_skid_buffer.sv
// Two-entry registered FIFO with valid/ready on both sides; input ready comes
// only from registered occupancy, so it never depends on out_rdy_i.
module evt_skid_buffer #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_vld_o,
    input  logic             out_rdy_i
);

    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             push;
    logic             pop;

    assign in_rdy_o   = (occ_q != 2'd2);
    assign out_vld_o  = (occ_q != 2'd0);
    assign out_data_o = head_q;
    assign push       = in_vld_i && in_rdy_o;
    assign pop        = out_vld_o && out_rdy_i;

    always_comb begin
        // NOTE: every next-state signal gets its default first, so no latch is inferred.
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = in_data_i;
                else               tail_d = in_data_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = in_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q  <= '0;
            // NOTE: the data registers are reset too, so the output bus reads zero out of reset.
            head_q <= '0;
            tail_q <= '0;
        end else begin
            // NOTE: non-blocking assignments for all state, so every flop samples pre-edge values.
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: rtl/evt_rr_arbiter.sv
// Round-robin merge of NUM_INPUTS event sources onto the pkt_assembler event
// input, tagging each event with its source and counting accepts per source.
module evt_rr_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int EVT_BITS   = spif_common_pkg::EVT_BITS,
    parameter int SRC_BITS   = $clog2(NUM_INPUTS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_INPUTS-1:0][EVT_BITS-1:0] evt_data_in,
    input  logic [NUM_INPUTS-1:0]               evt_vld_in,
    output logic [NUM_INPUTS-1:0]               evt_rdy_out,
    output logic [EVT_BITS-1:0]                 evt_data_out,
    output logic [SRC_BITS-1:0]                 evt_src_out,
    output logic                                evt_vld_out,
    input  logic                                evt_rdy_in,
    output logic [NUM_INPUTS-1:0][31:0]         evt_cnt_out
);

    import spif_common_pkg::grant_t;
    import spif_common_pkg::rr_next_grant;
    import spif_common_pkg::MAX_INPUTS;

    logic [SRC_BITS-1:0]                ptr_q, ptr_d;
    logic [NUM_INPUTS-1:0][31:0]        cnt_q, cnt_d;
    grant_t                             grant;
    logic [SRC_BITS-1:0]                g;
    logic                               buf_rdy;
    logic                               accept;
    logic [EVT_BITS+SRC_BITS-1:0]       push_data;
    logic [EVT_BITS+SRC_BITS-1:0]       head_data;

    assign grant     = rr_next_grant(MAX_INPUTS'(evt_vld_in), 3'(ptr_q), NUM_INPUTS);
    assign g         = SRC_BITS'(grant.idx);
    // Ready is built only from registered state and the granted valid.
    assign accept    = grant.found && buf_rdy && !reset;
    assign push_data = {evt_data_in[g], g};

    always_comb begin
        evt_rdy_out = '0;
        if (accept) evt_rdy_out[g] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (accept) begin
            ptr_d    = (int'(g) == NUM_INPUTS - 1) ? '0 : g + SRC_BITS'(1);
            cnt_d[g] = cnt_q[g] + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    evt_skid_buffer #(
        .WIDTH(EVT_BITS + SRC_BITS)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .in_data_i (push_data),
        .in_vld_i  (grant.found && !reset),
        .in_rdy_o  (buf_rdy),
        .out_data_o(head_data),
        .out_vld_o (evt_vld_out),
        .out_rdy_i (evt_rdy_in)
    );

    assign evt_data_out = head_data[EVT_BITS+SRC_BITS-1:SRC_BITS];
    assign evt_src_out  = head_data[SRC_BITS-1:0];
    assign evt_cnt_out  = cnt_q;

endmodule
